mux_nchannel_reg: RTL
=====================

MUX_NCHANNEL_REG -- requirements
Module: mux_nchannel_reg

Interface
REQ-001 Parameters SHALL be, one per line:
  DATAWIDTH, 8, width of each channel word.
  CHANNELS, 5, number of input channels (2..16).
  SELW, clog2(CHANNELS), width of select and out_chan.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all state updates on the rising edge.
  rst  in  1  reset, asynchronous and active-low.
  mode  in  1  0 = direct select, 1 = round-robin.
  select  in  SELW  channel index used in direct mode.
  in_data  in  CHANNELS*DATAWIDTH  packed words; channel k at bits [k*DATAWIDTH +: DATAWIDTH].
  in_valid  in  CHANNELS  per-channel word-available flags.
  in_ready  out  CHANNELS  per-channel accept strobes (combinational).
  out_data  out  DATAWIDTH  registered selected word.
  out_chan  out  SELW  index of the channel that supplied out_data.
  out_valid  out  1  out_data holds an unconsumed word.
  out_ready  in  1  downstream accepts out_data this cycle.
  sel_err  out  1  registered pulse: direct-mode select >= CHANNELS.

Function
REQ-003 The output stage SHALL be a single-entry register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-004 load SHALL equal (!out_valid || out_ready).
REQ-005 In direct mode, grant g SHALL be select, and only when select < CHANNELS and in_valid[select]=1.
REQ-006 In round-robin mode, grant g SHALL be the first channel with in_valid=1 searching rr_ptr, rr_ptr+1, ... with wrap modulo CHANNELS.
REQ-007 in_ready[g] SHALL equal load; every other in_ready bit SHALL be 0; with no grant, all in_ready bits SHALL be 0.
REQ-008 Transfer (in_valid[g] && in_ready[g]) SHALL set out_data <= word g, out_chan <= g and out_valid <= 1 at the next edge; latency is one cycle.
REQ-009 With no transfer, out_ready=1 SHALL clear out_valid; otherwise out_valid, out_data and out_chan SHALL hold.
REQ-010 Consumption and a new transfer in the same cycle SHALL keep out_valid=1 and load the new word, sustaining one word per cycle.
REQ-011 A round-robin transfer SHALL set rr_ptr <= (g+1) mod CHANNELS; rr_ptr SHALL hold in direct mode and on cycles without a transfer.
REQ-012 Direct mode with select >= CHANNELS SHALL produce no grant and SHALL set sel_err=1 for the following cycle; the pulse repeats each cycle the condition holds.
REQ-013 A mode change SHALL take effect on the same cycle's grant decision; a word already in the output register SHALL be unaffected.
REQ-014 out_data SHALL retain its last value while out_valid=0.
REQ-015 in_valid of non-granted channels SHALL have no effect on any state.

Reset
REQ-016 rst=0 SHALL immediately force out_valid=0, out_data=0, out_chan=0, rr_ptr=0 and sel_err=0, independent of clk.
REQ-017 A word held at reset assertion SHALL be discarded and not re-presented.
REQ-018 in_ready SHALL be all-ones-free (0) while rst=0.
REQ-019 Normal operation SHALL resume on the first rising clk edge after rst deasserts.

Structure
REQ-020 Shared package risc_spm_pkg SHALL hold the MODE_DIRECT=0 and MODE_RR=1 encodings and the default DATAWIDTH.
REQ-021 The round-robin search and pointer SHALL be a sub-module rr_arbiter (CHANNELS parameter; in_valid and rr_ptr in; one-hot grant and index out).
REQ-022 The output register and handshake SHALL live in mux_nchannel_reg.

Verification (CHANNELS=5, DATAWIDTH=8)
REQ-023 Direct mode, select=2, in_valid=5'b00100, word2=8'hA5, out_ready=1 -> in_ready=5'b00100; next cycle out_valid=1, out_data=A5, out_chan=2.
REQ-024 Direct mode, select=6 -> in_ready=0, out_valid stays 0, sel_err=1 on the following cycle.
REQ-025 RR mode, all in_valid=1, out_ready=1 for 7 cycles -> out_chan sequence 0,1,2,3,4,0,1, one word per cycle.
REQ-026 FULL with out_ready=0 for 3 cycles -> in_ready=0 and out_data constant; then out_ready=1 with in_valid[3]=1 -> same-cycle swap, out_valid stays 1.
REQ-027 RR mode, in_valid=5'b10001, rr_ptr=1 -> grant 4, then grant 0 (wrap).
REQ-028 rst=0 asserted mid-cycle while FULL -> out_valid drops before the next clk edge; after release, the first out_chan seen in RR mode is 0.

Source files
------------

// File: rtl/risc_spm_pkg.sv
// Shared definitions for the channel mux: mode encodings and default word width.
package risc_spm_pkg;

    localparam int DATAWIDTH_DEF = 8;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first requesting channel at or after rr_ptr, wrapping.
module rr_arbiter
    import risc_spm_pkg::*;
#(
    parameter int CHANNELS = 5,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] in_valid,
    input  logic [SELW-1:0]     rr_ptr,
    output logic [CHANNELS-1:0] gnt_onehot,
    output logic [SELW-1:0]     gnt_idx,
    output logic                gnt_found
);

    // Walk offsets 0..CHANNELS-1 from the pointer; the first hit wins.
    always_comb begin
        int          idx;
        logic [SELW-1:0] idx_s;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_found  = 1'b0;
        idx        = 0;
        idx_s      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= CHANNELS)
                idx = idx - CHANNELS;
            idx_s = SELW'(idx);
            if (!gnt_found && in_valid[idx_s]) begin
                gnt_found         = 1'b1;
                gnt_idx           = idx_s;
                gnt_onehot[idx_s] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nchannel_reg.sv
// N-channel mux with direct or round-robin selection into a single-entry
// registered output stage with valid/ready handshake.
module mux_nchannel_reg
    import risc_spm_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int CHANNELS  = 5,
    parameter int SELW      = $clog2(CHANNELS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode,
    input  logic [SELW-1:0]               select,
    input  logic [CHANNELS*DATAWIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]           in_valid,
    output logic [CHANNELS-1:0]           in_ready,
    output logic [DATAWIDTH-1:0]          out_data,
    output logic [SELW-1:0]               out_chan,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sel_err
);

    mode_e                              mode_q;
    logic [CHANNELS-1:0][DATAWIDTH-1:0] words;
    logic [SELW-1:0]                    rr_ptr;
    logic [CHANNELS-1:0]                rr_onehot;
    logic [SELW-1:0]                    rr_idx;
    logic                               rr_found;
    logic                               sel_ok;
    logic                               gnt_valid;
    logic [SELW-1:0]                    g;
    logic [CHANNELS-1:0]                gnt_onehot;
    logic                               load;
    logic                               xfer;

    assign mode_q = mode_e'(mode);
    assign words  = in_data;
    assign load   = !out_valid || out_ready;
    assign sel_ok = int'(select) < CHANNELS;

    rr_arbiter #(.CHANNELS(CHANNELS), .SELW(SELW)) u_arb (
        .in_valid   (in_valid),
        .rr_ptr     (rr_ptr),
        .gnt_onehot (rr_onehot),
        .gnt_idx    (rr_idx),
        .gnt_found  (rr_found)
    );

    // Grant decision follows the current mode with no pipelining.
    always_comb begin
        g          = '0;
        gnt_valid  = 1'b0;
        gnt_onehot = '0;
        if (mode_q == MODE_RR) begin
            g          = rr_idx;
            gnt_valid  = rr_found;
            gnt_onehot = rr_onehot;
        end else if (sel_ok && in_valid[select]) begin
            g          = select;
            gnt_valid  = 1'b1;
            gnt_onehot = CHANNELS'(1) << select;
        end
    end

    // Only the granted channel sees the accept strobe, and never during reset.
    assign in_ready = (rst && gnt_valid && load) ? gnt_onehot : '0;
    assign xfer     = rst && gnt_valid && load;

    // Output register, round-robin pointer and select-error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= (mode_q == MODE_DIRECT) && !sel_ok;
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= words[g];
                out_chan  <= g;
                if (mode_q == MODE_RR)
                    rr_ptr <= (g == SELW'(CHANNELS - 1)) ? '0 : g + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
